// File: rtl/des_sbox_sequencer.sv
// Iterative DES S-layer controller: feeds the eight 6-bit chunks of one round
// through a single shared S-box lookup port and assembles the 32-bit result.
module des_sbox_sequencer #(
    parameter int unsigned LOOKUP_LAT = 0   // 0: combinational lookup, 1: registered lookup
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] in_data,
    output logic [2:0]  lk_sel,
    output logic [5:0]  lk_in,
    input  logic [3:0]  lk_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);

    localparam int unsigned DATA_W   = 48;
    localparam int unsigned CHUNK_W  = 6;
    localparam int unsigned NIB_W    = 4;
    localparam int unsigned OUT_W    = 32;
    localparam int unsigned SEL_W    = 3;
    localparam int unsigned NUM_SBOX = 8;
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_SBOX - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_data;        // chunks not yet issued, next one in the MSBs
    logic [SEL_W-1:0]    r_idx;
    logic                r_issue_done;  // terminal flag so the index never wraps
    logic                r_in_ready;
    logic                r_out_valid;
    logic [OUT_W-1:0]    r_out_data;
    logic [SEL_W-1:0]    r_lk_sel;
    logic [CHUNK_W-1:0]  r_lk_in;
    logic                r_busy;

    logic                w_cap_en;
    logic [SEL_W-1:0]    w_cap_idx;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign lk_sel    = r_lk_sel;
    assign lk_in     = r_lk_in;
    assign busy      = r_busy;

    // Capture point: same cycle as issue, or one cycle behind for a registered lookup.
    generate
        if (LOOKUP_LAT == 0) begin : g_lat0
            assign w_cap_en  = (r_state == S_RUN) && !r_issue_done;
            assign w_cap_idx = r_idx;
        end else begin : g_lat1
            logic             r_cap_pend;
            logic [SEL_W-1:0] r_cap_idx;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cap_pend <= 1'b0;
                    r_cap_idx  <= '0;
                end else begin
                    r_cap_pend <= (r_state == S_RUN) && !r_issue_done;
                    r_cap_idx  <= r_idx;
                end
            end

            assign w_cap_en  = (r_state == S_RUN) && r_cap_pend;
            assign w_cap_idx = r_cap_idx;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_data       <= '0;
            r_idx        <= '0;
            r_issue_done <= 1'b0;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_lk_sel     <= '0;
            r_lk_in      <= '0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_lk_in      <= in_data[DATA_W-1 -: CHUNK_W];
                        r_data       <= {in_data[DATA_W-CHUNK_W-1:0], {CHUNK_W{1'b0}}};
                        r_lk_sel     <= '0;
                        r_idx        <= '0;
                        r_issue_done <= 1'b0;
                        r_out_data   <= '0;
                        r_in_ready   <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (!r_issue_done) begin
                        if (r_idx == LAST_IDX) begin
                            r_issue_done <= 1'b1;
                        end else begin
                            r_idx    <= r_idx + SEL_W'(1);
                            r_lk_sel <= r_idx + SEL_W'(1);
                            r_lk_in  <= r_data[DATA_W-1 -: CHUNK_W];
                            r_data   <= {r_data[DATA_W-CHUNK_W-1:0], {CHUNK_W{1'b0}}};
                        end
                    end
                    if (w_cap_en) begin
                        for (int k = 0; k < NUM_SBOX; k++) begin
                            if (w_cap_idx == SEL_W'(k)) begin
                                r_out_data[OUT_W-1-NIB_W*k -: NIB_W] <= lk_out;
                            end
                        end
                        if (w_cap_idx == LAST_IDX) begin
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_des_sbox_sequencer.sv
// Directed bench for des_sbox_sequencer: one instance per lookup latency,
// each wired to reference DES S-box tables.
module tb_des_sbox_sequencer;

    localparam int SB [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,
          0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,
          15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,
          3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,
          13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,
          13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,
          1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,
          13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,
          3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,
          14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,
          11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,
          10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,
          4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,
          13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,
          6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,
          1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,
          2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
    };

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid  [2];
    logic [47:0] in_data   [2];
    logic        out_ready [2];
    logic        in_ready  [2];
    logic        out_valid [2];
    logic [31:0] out_data  [2];
    logic [2:0]  lk_sel    [2];
    logic [5:0]  lk_in     [2];
    logic        busy      [2];
    logic [3:0]  lk_out0;
    logic [3:0]  lk_out1;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] sbox(input logic [2:0] sel, input logic [5:0] x);
        return 4'(SB[sel][{x[5], x[0], x[4:1]}]);
    endfunction

    function automatic logic [31:0] s_layer(input logic [47:0] d);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) r[31-4*k -: 4] = sbox(3'(k), d[47-6*k -: 6]);
        return r;
    endfunction

    assign lk_out0 = sbox(lk_sel[0], lk_in[0]);
    always_ff @(posedge clk) lk_out1 <= sbox(lk_sel[1], lk_in[1]);

    des_sbox_sequencer #(.LOOKUP_LAT(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .lk_sel(lk_sel[0]), .lk_in(lk_in[0]), .lk_out(lk_out0),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .busy(busy[0])
    );

    des_sbox_sequencer #(.LOOKUP_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .lk_sel(lk_sel[1]), .lk_in(lk_in[1]), .lk_out(lk_out1),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .busy(busy[1])
    );

    // Offer a word and wait (bounded) for the edge that accepts it.
    task automatic do_accept(input int d, input logic [47:0] w);
        logic rdy;
        int   edges;
        edges = 0;
        in_data[d]  = w;
        in_valid[d] = 1'b1;
        do begin
            rdy = in_ready[d];
            @(posedge clk); #1;
            edges++;
        end while (!rdy && edges < 64);
        in_valid[d] = 1'b0;
        n_checks++;
        if (!rdy) $display("FAIL accept_timeout dut%0d: in_ready=0 for %0d cycles, required 1", d, edges);
        else n_pass++;
    endtask

    // Called #1 after the accept edge; follows the lookup sequence until out_valid.
    task automatic wait_result(input int d, input logic [47:0] w, input int exp_lat);
        int         c;
        int         bad_c;
        logic [5:0] exp_chunk;
        logic       busy_ok;
        c = 0; bad_c = -1; busy_ok = 1'b1;
        while (!out_valid[d] && c < 40) begin
            exp_chunk = 6'(w >> (42 - 6*c));
            if (c < 8 && bad_c < 0 && (lk_sel[d] !== 3'(c) || lk_in[d] !== exp_chunk)) bad_c = c;
            if (busy[d] !== 1'b1 || in_ready[d] !== 1'b0) busy_ok = 1'b0;
            @(posedge clk); #1;
            c++;
        end
        n_checks++;
        if (bad_c >= 0) $display("FAIL lk_seq dut%0d: bad at cycle %0d sel=%0d in=%h, required sel=%0d in=%h",
                                 d, bad_c, lk_sel[d], lk_in[d], bad_c, 6'(w >> (42 - 6*bad_c)));
        else n_pass++;
        n_checks++;
        if (!busy_ok) $display("FAIL run_flags dut%0d: busy/in_ready wrong during RUN, required 1/0", d);
        else n_pass++;
        n_checks++;
        if (c !== exp_lat) $display("FAIL latency dut%0d: out_valid after %0d cycles, required %0d", d, c, exp_lat);
        else n_pass++;
        n_checks++;
        if (out_data[d] !== s_layer(w)) $display("FAIL out_data dut%0d in=%h: got %h, required %h",
                                                 d, w, out_data[d], s_layer(w));
        else n_pass++;
    endtask

    task automatic complete(input int d);
        out_ready[d] = 1'b1;
        @(posedge clk); #1;
        out_ready[d] = 1'b0;
        n_checks++;
        if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1 || busy[d] !== 1'b0)
            $display("FAIL handshake dut%0d: out_valid=%b in_ready=%b busy=%b, required 0 1 0",
                     d, out_valid[d], in_ready[d], busy[d]);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b0; in_data[d] = '0; out_ready[d] = 1'b0;
        end
        #12;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || out_data[d] !== 32'h0 ||
                lk_sel[d] !== 3'h0 || lk_in[d] !== 6'h0 || busy[d] !== 1'b0)
                $display("FAIL reset_values dut%0d: rdy=%b ov=%b od=%h sel=%h in=%h busy=%b, required 1 0 0 0 0 0",
                         d, in_ready[d], out_valid[d], out_data[d], lk_sel[d], lk_in[d], busy[d]);
            else n_pass++;
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_lat0_vectors();
        do_accept(0, 48'h0);
        wait_result(0, 48'h0, 8);
        complete(0);
        do_accept(0, 48'hFFFF_FFFF_FFFF);
        wait_result(0, 48'hFFFF_FFFF_FFFF, 8);
        complete(0);
    endtask

    task automatic test_lat1_vectors();
        do_accept(1, 48'h0);
        wait_result(1, 48'h0, 9);
        complete(1);
        do_accept(1, 48'hFFFF_FFFF_FFFF);
        wait_result(1, 48'hFFFF_FFFF_FFFF, 9);
        complete(1);
    endtask

    task automatic test_backpressure();
        logic [47:0] wa, wb;
        logic        hold_ok;
        wa = 48'h0123_4567_89AB;
        wb = 48'hA5C3_3C5A_0F1E;
        hold_ok = 1'b1;
        do_accept(0, wa);
        wait_result(0, wa, 8);
        in_data[0] = wb;
        for (int i = 0; i < 20; i++) begin
            in_valid[0] = (i % 2) == 0;
            @(posedge clk); #1;
            if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || busy[0] !== 1'b1 ||
                out_data[0] !== s_layer(wa)) hold_ok = 1'b0;
        end
        n_checks++;
        if (!hold_ok) $display("FAIL backpressure_hold: ov=%b rdy=%b od=%h, required 1 0 %h",
                               out_valid[0], in_ready[0], out_data[0], s_layer(wa));
        else n_pass++;
        in_valid[0]  = 1'b1;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        n_checks++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0)
            $display("FAIL release: in_ready=%b out_valid=%b, required 1 0", in_ready[0], out_valid[0]);
        else n_pass++;
        do_accept(0, wb);
        wait_result(0, wb, 8);
        complete(0);
    endtask

    task automatic test_reset_mid_run();
        do_accept(0, 48'hFEDC_BA98_7654);
        repeat (4) begin @(posedge clk); #1; end
        n_checks++;
        if (lk_sel[0] !== 3'd4) $display("FAIL pre_reset_index: lk_sel=%0d, required 4", lk_sel[0]);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || out_data[0] !== 32'h0 || busy[0] !== 1'b0)
            $display("FAIL mid_run_reset: rdy=%b ov=%b od=%h busy=%b, required 1 0 00000000 0",
                     in_ready[0], out_valid[0], out_data[0], busy[0]);
        else n_pass++;
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0)
            $display("FAIL post_reset_idle: ov=%b busy=%b, required 0 0", out_valid[0], busy[0]);
        else n_pass++;
        do_accept(0, 48'h0);
        wait_result(0, 48'h0, 8);
        complete(0);
    endtask

    task automatic test_back_to_back();
        logic [47:0] w;
        int          prev;
        int          now;
        prev = -1;
        out_ready[0] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            w = {16'($urandom()), $urandom()};
            do_accept(0, w);
            now = cyc;
            if (prev >= 0) begin
                n_checks++;
                if (now - prev !== 10) $display("FAIL accept_spacing word%0d: %0d cycles, required 10", i, now - prev);
                else n_pass++;
            end
            prev = now;
            wait_result(0, w, 8);
        end
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lat0_vectors();
        test_lat1_vectors();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/des_sbox_sequencer.md
Name: des_sbox_sequencer

Overview:
Iterative controller that time-multiplexes one shared S-box lookup port across all eight DES S-box groups of a round.
- Accepts a 48-bit word (E(R) xor Kn) through a valid/ready handshake.
- Steps the eight 6-bit chunks through the shared lookup, one per cycle.
- Assembles the 32-bit substitution result, before the P permutation, and presents it on a valid/ready output.
- Sits between the expansion/key-XOR stage and the P-permutation stage of the iterative DES round datapath.

Parameters:
LOOKUP_LAT, 0, latency of the shared lookup port in cycles. 0 = combinational return in the same cycle; 1 = registered return one cycle after select. Other values are illegal.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
in_valid  input  1  in_data valid
in_ready  output  1  sequencer can accept in_data
in_data  input  48  chunk k occupies bits [47-6k : 42-6k], k = 0..7 (S1 in MSBs)
lk_sel  output  3  S-box select for the shared lookup: 0 = S1 .. 7 = S8
lk_in  output  6  6-bit chunk to the selected S-box (bit5/bit0 = row, bits4:1 = column)
lk_out  input  4  lookup result
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts out_data
out_data  output  32  S1 result in [31:28] .. S8 result in [3:0]
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, any state, mid-operation included):
  - state = IDLE; in_ready = 1; out_valid = 0; out_data = 0; lk_sel = 0; lk_in = 0; busy = 0.
  - An in-flight operation is discarded. No partial result is ever presented.
- State machine: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready at a clock edge: latch in_data, clear issue index to 0, clear result to 0, go to RUN.
- RUN:
  - in_ready = 0.
  - Each cycle with issue index i < 8: lk_sel = i and lk_in = chunk i, both driven from registers.
  - The issue index increments by 1 per cycle.
  - LOOKUP_LAT = 0: lk_out is captured into out_data nibble i at the same edge that advances i.
  - LOOKUP_LAT = 1: lk_out is captured into nibble i-1 one cycle later.
  - RUN therefore lasts 8 + LOOKUP_LAT cycles.
  - The capture of nibble 7 moves the state to DONE and sets out_valid = 1 from the next cycle.
  - lk_sel/lk_in hold their last issued value once issuing ends.
- DONE:
  - out_valid = 1; out_data is stable and holds while out_ready = 0 (backpressure, unbounded).
  - On out_valid & out_ready: out_valid = 0 and the state returns to IDLE, so in_ready = 1 in the following cycle.
  - A new input is never accepted in the same cycle as the output handshake. Max throughput is one result per 10 + LOOKUP_LAT cycles.
- Latency: with acceptance at edge N, out_valid rises after edge N + 8 + LOOKUP_LAT.
- in_valid while not in IDLE is ignored; the source must hold it until in_ready.
- out_data nibbles are written only in RUN. Unwritten nibbles read 0 during RUN, which is not observable because out_valid = 0 then.
- The index counter is 3 bits plus a terminal flag and must not wrap into a second pass.

Test Plan:
1. Shared port wired to S1..S8 reference lookups, LOOKUP_LAT = 0. in_data = 48'h0 -> out_valid 8 cycles after accept; out_data = 32'hEFA72C4D.
2. in_data = 48'hFFFFFFFFFFFF -> out_data = 32'hD9CE3DCB. Check lk_sel sequence 0..7 on consecutive cycles and lk_in = 6'h3F each cycle.
3. LOOKUP_LAT = 1 with a registered lookup, same vectors as 1 and 2 -> identical out_data; out_valid 9 cycles after accept.
4. Hold out_ready = 0 for 20 cycles in DONE while pulsing in_valid with a new word.
   - Required: out_data stable, in_ready = 0, second word not taken.
   - Then raise out_ready: in_ready = 1 the following cycle and the second word is processed correctly.
5. Assert rst during RUN at issue index 4.
   - Required: immediately in_ready = 1, out_valid = 0, out_data = 0, busy = 0.
   - Next operation on in_data = 48'h0 returns 32'hEFA72C4D.
6. Back-to-back accepts with out_ready tied high, 16 random words checked against a software DES S-layer model.
   - Required: every result correct; spacing between accepts = 10 cycles at LOOKUP_LAT = 0.
